// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter for a single shared memory port.
// Data normally wins IDLE arbitration. Each transaction runs to completion on mem_ack, and the
// owner then receives a one-cycle registered ack.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the fetch starvation guard.
// With the guard on, a held fetch is forced through after STARVE_LIMIT consecutive data grants.
// With it off, data wins every IDLE arbitration.
module mem_arbiter
`ifdef MEM_ARB_STARVE_GUARD_EN
  #(
    parameter int unsigned STARVE_LIMIT = 4
  )
`endif
  (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic [1:0]  d_cmd,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [1:0]  mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        arb_busy
  );

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

  state_t      r_state;
  logic [1:0]  r_mem_cmd;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_if_ack;
  logic        r_d_ack;
  logic        r_busy;

  logic w_d_pend;
  logic w_if_pend;
  logic w_ack_cycle;
  logic w_force_fetch;
  logic w_grant_d;
  logic w_grant_i;

  // Pending requests. A requester whose ack is high this cycle is still holding the
  // request it just completed, so that request is masked out.
  assign w_d_pend    = ((d_cmd == CMD_LOAD) || (d_cmd == CMD_STORE)) && !r_d_ack;
  assign w_if_pend   = if_req && !r_if_ack;
  // No grant is made in an ack cycle. This gives the acked requester one cycle to present
  // its next command, so that a back-to-back data stream keeps its priority.
  assign w_ack_cycle = r_d_ack | r_if_ack;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;

  assign w_force_fetch = w_if_pend && (r_starve == Limit);

  // Starvation counter: counts data grants that overtake a waiting fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
    end else if (r_state == IDLE) begin
      if (w_grant_d) begin
        if (w_if_pend) begin
          r_starve <= (r_starve < Limit) ? r_starve + 4'd1 : r_starve;
        end else begin
          r_starve <= 4'd0;
        end
      end else if (w_grant_i) begin
        r_starve <= 4'd0;
      end
    end
  end
`else
  assign w_force_fetch = 1'b0;
`endif

  assign w_grant_d = !w_ack_cycle && w_d_pend && !w_force_fetch;
  assign w_grant_i = !w_ack_cycle && w_if_pend && !w_grant_d;

  // Arbitration FSM with registered memory-port outputs, acks and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_cmd   <= CMD_NONE;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= D_BUSY;
            r_mem_cmd   <= d_cmd;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_busy      <= 1'b1;
          end else if (w_grant_i) begin
            r_state    <= I_BUSY;
            r_mem_cmd  <= CMD_LOAD;
            r_mem_addr <= if_addr;
            r_busy     <= 1'b1;
          end
        end
        D_BUSY: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_cmd <= CMD_NONE;
            r_busy    <= 1'b0;
            r_d_ack   <= 1'b1;
            if (r_mem_cmd == CMD_LOAD) begin
              r_d_rdata <= mem_rdata;
            end
          end
        end
        I_BUSY: begin
          if (mem_ack) begin
            r_state    <= IDLE;
            r_mem_cmd  <= CMD_NONE;
            r_busy     <= 1'b0;
            r_if_ack   <= 1'b1;
            r_if_rdata <= mem_rdata;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_cmd <= CMD_NONE;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_cmd   = r_mem_cmd;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign arb_busy  = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus directed sequences for
// reset abandonment and fetch starvation.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic [1:0]  d_cmd;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        arb_busy;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arbiter #(.STARVE_LIMIT(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_cmd    (d_cmd),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_cmd  (mem_cmd),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .arb_busy (arb_busy)
  );
`else
  mem_arbiter u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_cmd    (d_cmd),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_cmd  (mem_cmd),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .arb_busy (arb_busy)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  d_cmd;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_ack;
    logic [31:0] e_if_rdata;
    logic        e_d_ack;
    logic [31:0] e_d_rdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs[18];
  logic exp_grant[10];
  logic got_grant[10];
  int   n_grants;

  initial begin
    // Inputs are sampled on the edge; expected values are the outputs after that edge.
    // Reset held, then mem_ack in IDLE with nothing pending.
    vecs[0]  = '{0, 0, 0,      0, 0,     0,     0, 0,            0, 0,     0,     0, 0,            0, 0,            0};
    vecs[1]  = '{1, 0, 0,      0, 0,     0,     1, 32'h12345678, 0, 0,     0,     0, 0,            0, 0,            0};
    vecs[2]  = '{1, 0, 0,      0, 0,     0,     1, 32'h12345678, 0, 0,     0,     0, 0,            0, 0,            0};
    vecs[3]  = '{1, 0, 0,      0, 0,     0,     1, 32'h12345678, 0, 0,     0,     0, 0,            0, 0,            0};
    // Fetch only, mem_ack in the first busy cycle; request still held during the ack cycle.
    vecs[4]  = '{1, 1, 32'h100, 0, 0,     0,     0, 0,            1, 32'h100, 0,     0, 0,            0, 0,            1};
    vecs[5]  = '{1, 1, 32'h100, 0, 0,     0,     1, 32'hDEADBEEF, 0, 32'h100, 0,     1, 32'hDEADBEEF, 0, 0,            0};
    vecs[6]  = '{1, 1, 32'h100, 0, 0,     0,     0, 0,            0, 32'h100, 0,     0, 32'hDEADBEEF, 0, 0,            0};
    vecs[7]  = '{1, 0, 0,      0, 0,     0,     0, 0,            0, 32'h100, 0,     0, 32'hDEADBEEF, 0, 0,            0};
    // Simultaneous fetch and STORE: store first, then the fetch, with a waited busy cycle.
    vecs[8]  = '{1, 1, 32'h200, 2, 32'h20, 32'h55, 0, 0,            2, 32'h20,  32'h55, 0, 32'hDEADBEEF, 0, 0,            1};
    vecs[9]  = '{1, 1, 32'h200, 2, 32'h20, 32'h55, 1, 32'hAAAA5555, 0, 32'h20,  32'h55, 0, 32'hDEADBEEF, 1, 0,            0};
    vecs[10] = '{1, 1, 32'h200, 0, 0,     0,     0, 0,            0, 32'h20,  32'h55, 0, 32'hDEADBEEF, 0, 0,            0};
    vecs[11] = '{1, 1, 32'h200, 0, 0,     0,     0, 0,            1, 32'h200, 32'h55, 0, 32'hDEADBEEF, 0, 0,            1};
    vecs[12] = '{1, 1, 32'h200, 1, 32'h40, 32'h77, 0, 0,            1, 32'h200, 32'h55, 0, 32'hDEADBEEF, 0, 0,            1};
    vecs[13] = '{1, 1, 32'h200, 1, 32'h40, 32'h77, 1, 32'h0BADF00D, 0, 32'h200, 32'h55, 1, 32'h0BADF00D, 0, 0,            0};
    // Data LOAD that waited through the fetch.
    vecs[14] = '{1, 0, 0,      1, 32'h40, 32'h77, 0, 0,            0, 32'h200, 32'h55, 0, 32'h0BADF00D, 0, 0,            0};
    vecs[15] = '{1, 0, 0,      1, 32'h40, 32'h77, 0, 0,            1, 32'h40,  32'h77, 0, 32'h0BADF00D, 0, 0,            1};
    vecs[16] = '{1, 0, 0,      1, 32'h40, 32'h77, 1, 32'hCAFEF00D, 0, 32'h40,  32'h77, 0, 32'h0BADF00D, 1, 32'hCAFEF00D, 0};
    vecs[17] = '{1, 0, 0,      0, 0,     0,     0, 0,            0, 32'h40,  32'h77, 0, 32'h0BADF00D, 0, 32'hCAFEF00D, 0};

    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_grant[i] = (i == 4) || (i == 9);
`else
      exp_grant[i] = 1'b0;
`endif
      got_grant[i] = 1'b0;
    end

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_cmd = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    for (int i = 0; i < 18; i++) begin
      rst_n     = vecs[i].rst_n;
      if_req    = vecs[i].if_req;
      if_addr   = vecs[i].if_addr;
      d_cmd     = vecs[i].d_cmd;
      d_addr    = vecs[i].d_addr;
      d_wdata   = vecs[i].d_wdata;
      mem_ack   = vecs[i].mem_ack;
      mem_rdata = vecs[i].mem_rdata;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d mem_cmd", i),   32'(mem_cmd),   32'(vecs[i].e_cmd));
      chk($sformatf("v%0d mem_addr", i),  mem_addr,       vecs[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata,      vecs[i].e_wdata);
      chk($sformatf("v%0d if_ack", i),    32'(if_ack),    32'(vecs[i].e_if_ack));
      chk($sformatf("v%0d if_rdata", i),  if_rdata,       vecs[i].e_if_rdata);
      chk($sformatf("v%0d d_ack", i),     32'(d_ack),     32'(vecs[i].e_d_ack));
      chk($sformatf("v%0d d_rdata", i),   d_rdata,        vecs[i].e_d_rdata);
      chk($sformatf("v%0d arb_busy", i),  32'(arb_busy),  32'(vecs[i].e_busy));
    end

    // Reset during D_BUSY, then a late mem_ack after release.
    d_cmd = 2'd1; d_addr = 32'h80; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid busy", 32'(arb_busy), 32'd1);
    chk("rst_mid cmd", 32'(mem_cmd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async busy", 32'(arb_busy), 32'd0);
    chk("rst_async cmd", 32'(mem_cmd), 32'd0);
    chk("rst_async addr", mem_addr, 32'd0);
    chk("rst_async d_rdata", d_rdata, 32'd0);
    d_cmd = 2'd0;
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("late_ack d_ack", 32'(d_ack), 32'd0);
    chk("late_ack busy", 32'(arb_busy), 32'd0);
    chk("late_ack cmd", 32'(mem_cmd), 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack d_ack2", 32'(d_ack), 32'd0);
    chk("late_ack d_rdata", d_rdata, 32'd0);

    // Fetch starvation: data LOADs re-presented back to back, fetch held; memory acks at once.
    d_cmd = 2'd1; d_addr = 32'h400; if_req = 1'b1; if_addr = 32'h300;
    n_grants = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (arb_busy && (n_grants < 10)) begin
        got_grant[n_grants] = (mem_addr == 32'h300);
        n_grants++;
      end
      mem_ack   = (mem_cmd != 2'd0);
      mem_rdata = 32'(c);
    end
    chk("starve grant count", 32'(n_grants), 32'd10);
    for (int g = 0; g < 10; g++) begin
      chk($sformatf("starve grant%0d is_fetch", g), 32'(got_grant[g]), 32'(exp_grant[g]));
    end

    d_cmd = 2'd0; if_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive data grants allowed while a fetch waits; legal range 1..15.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  instruction-fetch read request; held until if_ack.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_rdata  out  32  fetched word; valid while if_ack is high.
REQ-007 if_ack  out  1  one-cycle fetch completion pulse.
REQ-008 d_cmd  in  2  data command: 0 NONE, 1 LOAD, 2 STORE, 3 treated as NONE; held until d_ack.
REQ-009 d_addr  in  32  data address.
REQ-010 d_wdata  in  32  store data.
REQ-011 d_rdata  out  32  load data; valid while d_ack is high.
REQ-012 d_ack  out  1  one-cycle data completion pulse.
REQ-013 mem_cmd  out  2  command to the shared memory port, same encoding as d_cmd.
REQ-014 mem_addr  out  32  memory address.
REQ-015 mem_wdata  out  32  memory store data.
REQ-016 mem_rdata  in  32  memory read data; sampled when mem_ack is high.
REQ-017 mem_ack  in  1  memory completion; variable latency, at least 0 cycles after the command is presented.
REQ-018 arb_busy  out  1  high while a transaction is outstanding.

Function
REQ-019 The arbiter SHALL implement three states: IDLE, D_BUSY and I_BUSY.
REQ-020 In IDLE, a pending data request (d_cmd of 1 or 2, d_ack low) SHALL win over if_req, except where REQ-029 applies; the winner's request is latched and the FSM moves to D_BUSY or I_BUSY.
REQ-021 In IDLE, with only if_req pending (if_ack low), the arbiter SHALL latch if_addr and enter I_BUSY with a LOAD command.
REQ-022 While busy, mem_cmd, mem_addr and mem_wdata SHALL be driven from the latched registers; in IDLE, mem_cmd is NONE and addr/wdata hold their last values.
REQ-023 Changes to requester inputs during D_BUSY or I_BUSY SHALL be ignored.
REQ-024 On the edge where mem_ack is high in a busy state, the FSM SHALL return to IDLE.
- On that same edge, the ack of the owner SHALL be registered high for exactly the next cycle.
- For a LOAD or fetch, mem_rdata SHALL be captured into if_rdata or d_rdata.
REQ-025 d_rdata and if_rdata SHALL hold their values between acks; a STORE ack SHALL NOT change d_rdata.
REQ-026 A requester whose ack is high in the current cycle SHALL be ignored by IDLE arbitration in that cycle; this prevents a re-grant of a still-held request.
REQ-027 Minimum latency SHALL be 2 cycles from request sampled in IDLE to ack high, when mem_ack is returned in the first busy cycle.
REQ-028 mem_ack in IDLE SHALL be ignored, with no state or output change.
REQ-029 The starvation counter (4 bits, saturating at STARVE_LIMIT) SHALL behave as follows.
- It increments on each data grant made while if_req is pending.
- It clears on a fetch grant, and on a data grant made while no fetch is pending.
- When it equals STARVE_LIMIT and if_req is pending, the next IDLE grant SHALL go to the fetch.
REQ-030 arb_busy SHALL be high exactly in D_BUSY and I_BUSY.

Reset
REQ-031 While rst_n is low, the arbiter SHALL hold the following values, applied asynchronously.
- FSM in IDLE; mem_cmd NONE.
- mem_addr, mem_wdata, if_rdata and d_rdata all 0.
- if_ack, d_ack, arb_busy and the starvation counter all 0.
REQ-032 A reset mid-transaction SHALL abandon the transaction without any ack, and a late mem_ack after reset release SHALL be ignored per REQ-028.

Configuration
REQ-033 Macro MEM_ARB_STARVE_GUARD_EN controls the starvation guard.
- Defined: REQ-029 applies.
- Undefined: the counter and the STARVE_LIMIT override are absent, and data strictly wins every IDLE arbitration.

Verification
REQ-034 Fetch only, if_req=1 with if_addr=0x100, memory returns 0xDEADBEEF with mem_ack in the first busy cycle -> mem_cmd=1 and mem_addr=0x100 for one cycle; if_ack=1 with if_rdata=0xDEADBEEF two cycles after the request.
REQ-035 Simultaneous if_req and d_cmd=2 (d_addr=0x20, d_wdata=0x55) -> STORE served first (mem_cmd=2, mem_wdata=0x55), d_ack pulses, then the fetch is granted; d_rdata is unchanged.
REQ-036 Guard enabled, STARVE_LIMIT=4, continuous data LOADs and if_req held -> exactly 4 data grants, then 1 fetch grant, then data resumes.
REQ-037 Guard disabled, same stimulus as REQ-036 -> no fetch grant while data requests persist.
REQ-038 rst_n pulsed low during D_BUSY before mem_ack, then mem_ack=1 arrives after release -> no d_ack, FSM stays IDLE, mem_cmd=0.
REQ-039 mem_ack held high for 3 cycles in IDLE with no requests -> no ack pulses and no state change.
